// File: rtl/pixel_write_ctrl.sv
// Pixel-buffer to SRAM write controller: each 24-bit pixel becomes two 16-bit words.
// Define PWC_FRAME_CNT_EN to add the frame_cnt output.
module pixel_write_ctrl #(
  parameter int unsigned NUM_PIXELS = 307200,
  parameter int unsigned PIX_ID_W   = 19
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                pb_empty,
  input  logic [PIX_ID_W-1:0] pix_id,
  input  logic [23:0]         pix_rgb,
  output logic                pb_re,
  output logic                sram_req,
  input  logic                sram_grant,
  output logic [19:0]         sram_addr,
  output logic [15:0]         sram_wdata,
  output logic                sram_we_b,
  output logic                frame_done,
  output logic [PIX_ID_W-1:0] pix_cnt,
`ifdef PWC_FRAME_CNT_EN
  output logic                err_oob,
  output logic [15:0]         frame_cnt
`else
  output logic                err_oob
`endif
);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, SKIP} state_t;

  localparam logic [PIX_ID_W-1:0] LAST_CNT = PIX_ID_W'(NUM_PIXELS - 1);

  state_t              r_state;
  logic [PIX_ID_W-1:0] r_id;
  logic [7:0]          r_red;
  logic                r_sram_req;
  logic [19:0]         r_sram_addr;
  logic [15:0]         r_sram_wdata;
  logic [PIX_ID_W-1:0] r_pix_cnt;
  logic                r_frame_done;
  logic                r_err_oob;

  logic                w_complete;
  logic                w_pop;
  logic                w_last_pix;
  logic                w_in_oob;
  logic [31:0]         w_id_ext;
  logic [PIX_ID_W:0]   w_addr_lo;
  logic [PIX_ID_W:0]   w_addr_hi;

  // SKIP is the single dead cycle an out-of-range pixel spends before it counts as complete
  assign w_complete = ((r_state == WR_HI) && sram_grant) || (r_state == SKIP);
  assign w_pop      = rst_b && !pb_empty && ((r_state == IDLE) || w_complete);
  assign w_last_pix = (r_pix_cnt == LAST_CNT);
  assign w_id_ext   = 32'(pix_id);
  assign w_in_oob   = (w_id_ext >= NUM_PIXELS);
  assign w_addr_lo  = {pix_id, 1'b0};
  assign w_addr_hi  = {r_id, 1'b1};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= IDLE;
      r_id         <= '0;
      r_red        <= '0;
      r_sram_req   <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_pix_cnt    <= '0;
      r_frame_done <= 1'b0;
      r_err_oob    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_complete) begin
        if (w_last_pix) begin
          r_pix_cnt    <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_pix_cnt <= r_pix_cnt + PIX_ID_W'(1);
        end
      end
      // A pop overrides the return to IDLE so completion and the next load share a cycle
      if (w_pop) begin
        r_id  <= pix_id;
        r_red <= pix_rgb[23:16];
        if (w_in_oob) begin
          r_state    <= SKIP;
          r_sram_req <= 1'b0;
          r_err_oob  <= 1'b1;
        end else begin
          r_state      <= WR_LO;
          r_sram_req   <= 1'b1;
          r_sram_addr  <= 20'(w_addr_lo);
          r_sram_wdata <= pix_rgb[15:0];
        end
      end else if (w_complete) begin
        r_state    <= IDLE;
        r_sram_req <= 1'b0;
      end else if ((r_state == WR_LO) && sram_grant) begin
        r_state      <= WR_HI;
        r_sram_addr  <= 20'(w_addr_hi);
        r_sram_wdata <= {8'h00, r_red};
      end
    end
  end

  assign pb_re      = w_pop;
  assign sram_req   = r_sram_req;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_we_b  = ~(r_sram_req & sram_grant);
  assign frame_done = r_frame_done;
  assign pix_cnt    = r_pix_cnt;
  assign err_oob    = r_err_oob;

`ifdef PWC_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_frame_cnt <= '0;
    end else if (w_complete && w_last_pix) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_pixel_write_ctrl.sv
// Directed bench for pixel_write_ctrl: instance A uses the full frame size,
// instance B uses a 4-pixel frame to reach the wrap and out-of-range cases quickly.
module tb_pixel_write_ctrl;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        aPbEmpty, aPbRe, aGrant, aReq, aWeB, aFrameDone, aErrOob;
  logic [18:0] aPixId, aPixCnt;
  logic [23:0] aPixRgb;
  logic [19:0] aAddr;
  logic [15:0] aWdata;

  logic        bPbEmpty, bPbRe, bGrant, bReq, bWeB, bFrameDone, bErrOob;
  logic [18:0] bPixId, bPixCnt;
  logic [23:0] bPixRgb;
  logic [19:0] bAddr;
  logic [15:0] bWdata;

`ifdef PWC_FRAME_CNT_EN
  logic [15:0] aFrameCnt, bFrameCnt;
`endif

  // Show-ahead FIFO models; head advances on each pop strobe
  logic [18:0] aIdMem [0:63];
  logic [23:0] aRgbMem [0:63];
  logic [18:0] bIdMem [0:63];
  logic [23:0] bRgbMem [0:63];
  int aHead = 0, aTail = 0, bHead = 0, bTail = 0;

  always_comb begin
    aPbEmpty = (aHead == aTail);
    aPixId   = aIdMem[aHead[5:0]];
    aPixRgb  = aRgbMem[aHead[5:0]];
    bPbEmpty = (bHead == bTail);
    bPixId   = bIdMem[bHead[5:0]];
    bPixRgb  = bRgbMem[bHead[5:0]];
  end

  always @(posedge clk) begin
    if (aPbRe) aHead <= aHead + 1;
    if (bPbRe) bHead <= bHead + 1;
  end

  pixel_write_ctrl dutA (
    .clk(clk), .rst_b(rst_b), .pb_empty(aPbEmpty), .pix_id(aPixId), .pix_rgb(aPixRgb),
    .pb_re(aPbRe), .sram_req(aReq), .sram_grant(aGrant), .sram_addr(aAddr),
    .sram_wdata(aWdata), .sram_we_b(aWeB), .frame_done(aFrameDone), .pix_cnt(aPixCnt),
`ifdef PWC_FRAME_CNT_EN
    .err_oob(aErrOob), .frame_cnt(aFrameCnt)
`else
    .err_oob(aErrOob)
`endif
  );

  pixel_write_ctrl #(.NUM_PIXELS(4), .PIX_ID_W(19)) dutB (
    .clk(clk), .rst_b(rst_b), .pb_empty(bPbEmpty), .pix_id(bPixId), .pix_rgb(bPixRgb),
    .pb_re(bPbRe), .sram_req(bReq), .sram_grant(bGrant), .sram_addr(bAddr),
    .sram_wdata(bWdata), .sram_we_b(bWeB), .frame_done(bFrameDone), .pix_cnt(bPixCnt),
`ifdef PWC_FRAME_CNT_EN
    .err_oob(bErrOob), .frame_cnt(bFrameCnt)
`else
    .err_oob(bErrOob)
`endif
  );

  localparam logic [19:0] B2B_ADDR [8] = '{20'd40, 20'd41, 20'd42, 20'd43, 20'd44, 20'd45, 20'd46, 20'd47};
  localparam logic [15:0] B2B_DATA [8] = '{16'h2233, 16'h0011, 16'h5566, 16'h0044,
                                           16'h8899, 16'h0077, 16'hBBCC, 16'h00AA};
  localparam logic        B2B_RE   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic pushA(input logic [18:0] id, input logic [23:0] rgb);
    aIdMem[aTail[5:0]]  = id;
    aRgbMem[aTail[5:0]] = rgb;
    aTail = aTail + 1;
  endtask

  task automatic pushB(input logic [18:0] id, input logic [23:0] rgb);
    bIdMem[bTail[5:0]]  = id;
    bRgbMem[bTail[5:0]] = rgb;
    bTail = bTail + 1;
  endtask

  // Leaves both DUTs held in reset, 1 time unit after a rising edge
  task automatic holdReset;
    rst_b  = 1'b0;
    aGrant = 1'b1;
    bGrant = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    aGrant = 1'b1;
    bGrant = 1'b1;
    rst_b  = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_b = 1'b0;
    #1;
    total++;
    if (aPbRe !== 1'b0 || aReq !== 1'b0 || aWeB !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_ctrl got re=%b req=%b we_b=%b exp re=0 req=0 we_b=1", aPbRe, aReq, aWeB);
    end
    total++;
    if (aAddr !== 20'd0 || aWdata !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_bus got addr=%0d data=%h exp addr=0 data=0000", aAddr, aWdata);
    end
    total++;
    if (aPixCnt !== 19'd0 || aFrameDone !== 1'b0 || aErrOob !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_status got cnt=%0d fd=%b oob=%b exp 0/0/0", aPixCnt, aFrameDone, aErrOob);
    end
  endtask

  task automatic test_single_pixel;
    holdReset();
    pushA(19'd5, 24'hA1B2C3);
    rst_b = 1'b1;
    #1;
    total++;
    if (aPbRe !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_pop got=%b exp=1", aPbRe);
    end
    @(posedge clk); #1;
    total++;
    if (aReq !== 1'b1 || aWeB !== 1'b0 || aAddr !== 20'd10 || aWdata !== 16'hB2C3 || aPbRe !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_lo got req=%b we_b=%b addr=%0d data=%h re=%b exp 1/0/10/b2c3/0",
               aReq, aWeB, aAddr, aWdata, aPbRe);
    end
    @(posedge clk); #1;
    total++;
    if (aReq !== 1'b1 || aWeB !== 1'b0 || aAddr !== 20'd11 || aWdata !== 16'h00A1) begin
      bad++;
      $display("[TB] FAIL single_hi got req=%b we_b=%b addr=%0d data=%h exp 1/0/11/00a1", aReq, aWeB, aAddr, aWdata);
    end
    @(posedge clk); #1;
    total++;
    if (aPixCnt !== 19'd1 || aReq !== 1'b0 || aWeB !== 1'b1 || aAddr !== 20'd11 || aWdata !== 16'h00A1) begin
      bad++;
      $display("[TB] FAIL single_idle got cnt=%0d req=%b we_b=%b addr=%0d data=%h exp 1/0/1/11/00a1",
               aPixCnt, aReq, aWeB, aAddr, aWdata);
    end
  endtask

  task automatic test_back_to_back;
    holdReset();
    pushA(19'd20, 24'h112233);
    pushA(19'd21, 24'h445566);
    pushA(19'd22, 24'h778899);
    pushA(19'd23, 24'hAABBCC);
    rst_b = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      total++;
      if (aReq !== 1'b1 || aWeB !== 1'b0 || aAddr !== B2B_ADDR[k] || aWdata !== B2B_DATA[k] || aPbRe !== B2B_RE[k]) begin
        bad++;
        $display("[TB] FAIL b2b_cycle%0d got req=%b we_b=%b addr=%0d data=%h re=%b exp 1/0/%0d/%h/%b",
                 k, aReq, aWeB, aAddr, aWdata, aPbRe, B2B_ADDR[k], B2B_DATA[k], B2B_RE[k]);
      end
    end
    @(posedge clk); #1;
    total++;
    if (aReq !== 1'b0 || aPixCnt !== 19'd4) begin
      bad++;
      $display("[TB] FAIL b2b_end got req=%b cnt=%0d exp req=0 cnt=4", aReq, aPixCnt);
    end
  endtask

  task automatic test_grant_stall;
    holdReset();
    pushA(19'd7, 24'hC0FFEE);
    rst_b = 1'b1;
    #1;
    @(posedge clk); #1;
    total++;
    if (aAddr !== 20'd14 || aWdata !== 16'hFFEE || aWeB !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_lo got addr=%0d data=%h we_b=%b exp 14/ffee/0", aAddr, aWdata, aWeB);
    end
    @(posedge clk); #1;
    aGrant = 1'b0;
    #1;
    total++;
    if (aAddr !== 20'd15 || aWdata !== 16'h00C0 || aWeB !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stall_hi_enter got addr=%0d data=%h we_b=%b exp 15/00c0/1", aAddr, aWdata, aWeB);
    end
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      total++;
      if (aReq !== 1'b1 || aWeB !== 1'b1 || aAddr !== 20'd15 || aWdata !== 16'h00C0 || aPixCnt !== 19'd0) begin
        bad++;
        $display("[TB] FAIL stall_wait%0d got req=%b we_b=%b addr=%0d data=%h cnt=%0d exp 1/1/15/00c0/0",
                 k, aReq, aWeB, aAddr, aWdata, aPixCnt);
      end
    end
    aGrant = 1'b1;
    #1;
    total++;
    if (aWeB !== 1'b0 || aAddr !== 20'd15) begin
      bad++;
      $display("[TB] FAIL stall_release got we_b=%b addr=%0d exp we_b=0 addr=15", aWeB, aAddr);
    end
    @(posedge clk); #1;
    total++;
    if (aPixCnt !== 19'd1 || aReq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_done got cnt=%0d req=%b exp cnt=1 req=0", aPixCnt, aReq);
    end
  endtask

  task automatic test_frame_wrap;
    int pulses;
    int pulseCycle;
    pulses = 0;
    pulseCycle = -1;
    holdReset();
    pushB(19'd0, 24'h010101);
    pushB(19'd1, 24'h020202);
    pushB(19'd2, 24'h030303);
    pushB(19'd3, 24'h040404);
    pushB(19'd0, 24'h050505);
    rst_b = 1'b1;
    #1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bFrameDone === 1'b1) begin
        pulses++;
        pulseCycle = c;
        total++;
        if (bPixCnt !== 19'd0) begin
          bad++;
          $display("[TB] FAIL wrap_cnt_at_pulse got=%0d exp=0", bPixCnt);
        end
      end
    end
    total++;
    if (pulses !== 1 || pulseCycle !== 9) begin
      bad++;
      $display("[TB] FAIL wrap_pulse got pulses=%0d cycle=%0d exp pulses=1 cycle=9", pulses, pulseCycle);
    end
    total++;
    if (bPixCnt !== 19'd1 || bFrameDone !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wrap_end got cnt=%0d fd=%b exp cnt=1 fd=0", bPixCnt, bFrameDone);
    end
`ifdef PWC_FRAME_CNT_EN
    total++;
    if (bFrameCnt !== 16'd1) begin
      bad++;
      $display("[TB] FAIL wrap_frame_cnt got=%0d exp=1", bFrameCnt);
    end
`endif
  endtask

  task automatic test_oob;
    holdReset();
    pushB(19'd4, 24'hFFFFFF);
    pushB(19'd1, 24'h123456);
    rst_b = 1'b1;
    #1;
    @(posedge clk); #1;
    total++;
    if (bReq !== 1'b0 || bWeB !== 1'b1 || bAddr !== 20'd0 || bErrOob !== 1'b1 || bPixCnt !== 19'd0 || bPbRe !== 1'b1) begin
      bad++;
      $display("[TB] FAIL oob_skip got req=%b we_b=%b addr=%0d oob=%b cnt=%0d re=%b exp 0/1/0/1/0/1",
               bReq, bWeB, bAddr, bErrOob, bPixCnt, bPbRe);
    end
    @(posedge clk); #1;
    total++;
    if (bPixCnt !== 19'd1 || bReq !== 1'b1 || bAddr !== 20'd2 || bWdata !== 16'h3456) begin
      bad++;
      $display("[TB] FAIL oob_next_lo got cnt=%0d req=%b addr=%0d data=%h exp 1/1/2/3456", bPixCnt, bReq, bAddr, bWdata);
    end
    @(posedge clk); #1;
    total++;
    if (bAddr !== 20'd3 || bWdata !== 16'h0012) begin
      bad++;
      $display("[TB] FAIL oob_next_hi got addr=%0d data=%h exp 3/0012", bAddr, bWdata);
    end
    @(posedge clk); #1;
    total++;
    if (bPixCnt !== 19'd2 || bErrOob !== 1'b1 || bReq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL oob_sticky got cnt=%0d oob=%b req=%b exp 2/1/0", bPixCnt, bErrOob, bReq);
    end
  endtask

  task automatic test_mid_write_reset;
    holdReset();
    pushA(19'd9, 24'h010203);
    pushA(19'd10, 24'h040506);
    rst_b = 1'b1;
    #1;
    @(posedge clk); #1;
    total++;
    if (aReq !== 1'b1 || aAddr !== 20'd18 || aWdata !== 16'h0203) begin
      bad++;
      $display("[TB] FAIL midrst_lo got req=%b addr=%0d data=%h exp 1/18/0203", aReq, aAddr, aWdata);
    end
    rst_b = 1'b0;
    #1;
    total++;
    if (aReq !== 1'b0 || aWeB !== 1'b1 || aAddr !== 20'd0 || aWdata !== 16'd0 || aPbRe !== 1'b0 || bErrOob !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_async got req=%b we_b=%b addr=%0d data=%h re=%b oobB=%b exp 0/1/0/0000/0/0",
               aReq, aWeB, aAddr, aWdata, aPbRe, bErrOob);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    #1;
    total++;
    if (aPbRe !== 1'b1 || aReq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_release got re=%b req=%b exp re=1 req=0", aPbRe, aReq);
    end
    @(posedge clk); #1;
    total++;
    if (aReq !== 1'b1 || aAddr !== 20'd20 || aWdata !== 16'h0506) begin
      bad++;
      $display("[TB] FAIL midrst_next_lo got req=%b addr=%0d data=%h exp 1/20/0506", aReq, aAddr, aWdata);
    end
    @(posedge clk); #1;
    total++;
    if (aAddr !== 20'd21 || aWdata !== 16'h0004) begin
      bad++;
      $display("[TB] FAIL midrst_next_hi got addr=%0d data=%h exp 21/0004", aAddr, aWdata);
    end
    @(posedge clk); #1;
    total++;
    if (aPixCnt !== 19'd1 || aReq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_count got cnt=%0d req=%b exp cnt=1 req=0", aPixCnt, aReq);
    end
  endtask

  initial begin
    aGrant = 1'b1;
    bGrant = 1'b1;
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_grant_stall();
    test_frame_wrap();
    test_oob();
    test_mid_write_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_write_ctrl.md
PIXEL_WRITE_CTRL -- requirements
Module: pixel_write_ctrl

Interface
REQ-001 Parameter NUM_PIXELS, default 307200, number of pixels per frame (640x480).
REQ-002 Parameter PIX_ID_W, default 19, width of the pixel ID.
REQ-003 clk  input  1  single clock; all logic clocked on its rising edge.
REQ-004 rst_b  input  1  asynchronous active-low reset.
REQ-005 pb_empty  input  1  pixel-buffer FIFO empty; the FIFO head is valid when low.
REQ-006 pix_id  input  PIX_ID_W  pixel ID at the FIFO head.
REQ-007 pix_rgb  input  24  colour at the FIFO head, {R,G,B}.
REQ-008 pb_re  output  1  FIFO pop strobe.
REQ-009 sram_req  output  1  SRAM write-port request to the frame-buffer arbiter.
REQ-010 sram_grant  input  1  arbiter grant; a write completes in any cycle where sram_req and sram_grant are both high.
REQ-011 sram_addr  output  20  SRAM word address.
REQ-012 sram_wdata  output  16  SRAM write data.
REQ-013 sram_we_b  output  1  SRAM write enable, active-low; equals ~(sram_req & sram_grant).
REQ-014 frame_done  output  1  one-cycle pulse when the last pixel of a frame is written.
REQ-015 pix_cnt  output  PIX_ID_W  number of pixels completed in the current frame.
REQ-016 err_oob  output  1  sticky flag: a pixel ID >= NUM_PIXELS was received.

Function
REQ-017 The FSM SHALL have the states IDLE, WR_LO and WR_HI.
REQ-018 In IDLE with pb_empty low: assert pb_re for one cycle, latch pix_id and pix_rgb, and go to WR_LO.
REQ-019 pb_re SHALL never be asserted while pb_empty is high.
REQ-020 In WR_LO: sram_req=1, sram_addr={id,1'b0}, sram_wdata=rgb[15:0]; on grant go to WR_HI, otherwise hold all outputs.
REQ-021 In WR_HI: sram_req=1, sram_addr={id,1'b1}, sram_wdata={8'h00,rgb[23:16]}; on grant the pixel is complete.
REQ-022 On completion with pb_empty low: assert pb_re in the same cycle, latch the next entry and go directly to WR_LO.
REQ-023 On completion with pb_empty high: go to IDLE.
REQ-024 Sustained throughput SHALL be one pixel per 2 cycles under continuous grant.
REQ-025 Latency from the pop cycle to the first write SHALL be one cycle (WR_LO is entered on the next cycle).
REQ-026 pix_cnt SHALL increment by 1 on each completion.
REQ-027 When a completion makes pix_cnt reach NUM_PIXELS: pix_cnt wraps to 0 and frame_done pulses high in the following cycle only.
REQ-028 A latched id >= NUM_PIXELS SHALL set err_oob.
REQ-029 An out-of-range pixel SHALL skip WR_LO and WR_HI (no SRAM access) and still count as one completion in the cycle after its pop.
REQ-030 sram_req SHALL be 0 in IDLE, and sram_addr and sram_wdata SHALL hold their last values in IDLE.
REQ-031 Grant may stall indefinitely; no state, count or latched data SHALL change while waiting.

Reset
REQ-032 Asserting rst_b low at any time SHALL immediately force: state=IDLE, pb_re=0, sram_req=0, sram_we_b=1, sram_addr=0, sram_wdata=0, pix_cnt=0, frame_done=0, err_oob=0.
REQ-033 A pixel in flight when reset asserts SHALL be dropped; it is neither re-popped nor counted.
REQ-034 Leaving reset SHALL take effect at the first rising clk edge after rst_b goes high, with no extra idle cycles.

Configuration
REQ-035 Macro PWC_FRAME_CNT_EN SHALL control an optional frame counter.
REQ-036 With PWC_FRAME_CNT_EN defined: add output frame_cnt [15:0], reset to 0, incremented with each frame_done pulse, wrapping from 16'hFFFF to 0.
REQ-037 Without PWC_FRAME_CNT_EN: the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 Single pixel: FIFO holds id=5, rgb=24'hA1B2C3, grant tied high -> pb_re for 1 cycle; writes addr 10 data 16'hB2C3, then addr 11 data 16'h00A1; pix_cnt=1.
REQ-039 Back-to-back: FIFO holds 4 entries, grant high -> 8 consecutive write cycles with no bubble and pb_re every 2nd cycle.
REQ-040 Grant stall: grant low for 7 cycles during WR_HI -> addr/data held stable, sram_we_b high, pix_cnt unchanged; write occurs on the cycle grant rises.
REQ-041 Frame wrap: NUM_PIXELS=4, push 5 pixels -> frame_done pulses once after the 4th completion, then pix_cnt=1; with PWC_FRAME_CNT_EN defined, frame_cnt=1.
REQ-042 OOB: id=NUM_PIXELS -> no SRAM access, err_oob=1 and stays high, pix_cnt increments.
REQ-043 Mid-write reset: rst_b low during WR_LO -> all outputs take reset values asynchronously; after release the next FIFO entry is processed normally.
